fan_pwm_driver: RTL

FAN_PWM_DRIVER -- requirements
Module: fan_pwm_driver

---
 rtl/fan_pkg.sv | 38 +++
 rtl/fan_pwm_driver_if.sv | 32 +++
 rtl/fan_pwm_timebase.sv | 45 ++++
 rtl/fan_pwm_driver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// Fan PWM driver shared definitions.
// Holds the controller state encoding, level/phase widths, counter width,
// parameter defaults and the single-step level helper used by the ramp logic.
package fan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KICK  = 3'd1,
        ST_RAMP  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } fan_state_t;

    localparam int               LEVEL_W   = 4;
    localparam logic [LEVEL_W-1:0] PHASE_MAX = 4'd14;
    localparam int               CNT_W     = 16;

    localparam int CLK_DIV_DEF       = 4;
    localparam int RAMP_PERIODS_DEF  = 2;
    localparam int KICK_PERIODS_DEF  = 4;
    localparam int STALL_PERIODS_DEF = 8;

    // One level step toward tgt; saturates by construction (only moves when
    // tgt is strictly above/below cur), so the level can never wrap.
    function automatic logic [LEVEL_W-1:0] step_toward(
        input logic [LEVEL_W-1:0] cur,
        input logic [LEVEL_W-1:0] tgt
    );
        if (tgt > cur) begin
            return cur + LEVEL_W'(1);
        end else if (tgt < cur) begin
            return cur - LEVEL_W'(1);
        end else begin
            return cur;
        end
    endfunction

endpackage

// File: rtl/fan_pwm_driver_if.sv
// Fan PWM driver signal bundle.
// master: controller side (drives fan level request, tach in tach builds).
// slave : driver side (drives pwm_out, cur_level, busy, stall).
// Optional macro FAN_TACH_EN adds the asynchronous tach input.
interface fan_pwm_driver_if;
    import fan_pkg::*;

    logic [LEVEL_W-1:0] fan;
`ifdef FAN_TACH_EN
    logic               tach;
`endif
    logic               pwm_out;
    logic [LEVEL_W-1:0] cur_level;
    logic               busy;
    logic               stall;

    modport master (
        output fan,
`ifdef FAN_TACH_EN
        output tach,
`endif
        input  pwm_out, cur_level, busy, stall
    );

    modport slave (
        input  fan,
`ifdef FAN_TACH_EN
        input  tach,
`endif
        output pwm_out, cur_level, busy, stall
    );
endinterface

// File: rtl/fan_pwm_timebase.sv
// PWM timebase: prescaler 0..CLK_DIV-1 and 15-step phase counter 0..14.
// Ports: clk, rst (sync active-high), tick (prescaler at CLK_DIV-1),
//        boundary (tick on phase 14, i.e. last clk of a PWM period), phase.
module fan_pwm_timebase
    import fan_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic               tick,
    output logic               boundary,
    output logic [LEVEL_W-1:0] phase
);
    localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0]      presc_r;
    logic [LEVEL_W-1:0] phase_r;

    assign tick     = (presc_r == PRESC_MAX);
    assign boundary = tick && (phase_r == PHASE_MAX);
    assign phase    = phase_r;

    // Prescaler and phase counter; phase wraps 14 -> 0 on the boundary tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
            phase_r <= '0;
        end else begin
            if (tick) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + PW'(1);
            end
            if (boundary) begin
                phase_r <= '0;
            end else if (tick) begin
                phase_r <= phase_r + LEVEL_W'(1);
            end else begin
                phase_r <= phase_r;
            end
        end
    end
endmodule

// File: rtl/fan_pwm_driver.sv
// Fan PWM driver: soft-start kick, ramped level changes and optional stall
// detection. All state changes happen on PWM period boundaries.
// Ports: clk, rst (sync active-high), bus (fan_pwm_driver_if.slave):
//   fan in (requested level), pwm_out, cur_level, busy (KICK/RAMP),
//   stall (FAULT). Macro FAN_TACH_EN adds tach input and stall detection;
//   without it stall is tied low and FAULT is never entered.
// Every output is a register fed from the FSM/timebase registers, so all
// outputs trail the internal state by exactly one clk.
module fan_pwm_driver
    import fan_pkg::*;
#(
    parameter int CLK_DIV       = CLK_DIV_DEF,
    parameter int RAMP_PERIODS  = RAMP_PERIODS_DEF,
    parameter int KICK_PERIODS  = KICK_PERIODS_DEF
`ifdef FAN_TACH_EN
    ,
    parameter int STALL_PERIODS = STALL_PERIODS_DEF
`endif
) (
    input  logic            clk,
    input  logic            rst,
    fan_pwm_driver_if.slave bus
);
    logic               tick_s;
    logic               boundary_s;
    logic [LEVEL_W-1:0] phase_s;
    logic [LEVEL_W-1:0] step_s;

    fan_state_t         state_r;
    logic [LEVEL_W-1:0] level_r;
    logic [CNT_W-1:0]   kick_cnt_r;
    logic [CNT_W-1:0]   ramp_cnt_r;
    logic               tick_d_r;
    logic               pwm_out_r;
    logic [LEVEL_W-1:0] cur_level_r;
    logic               busy_r;

    fan_pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick_s),
        .boundary (boundary_s),
        .phase    (phase_s)
    );

    // Direction is recomputed from the live request at every step.
    assign step_s = step_toward(level_r, bus.fan);

`ifdef FAN_TACH_EN
    logic [2:0]       tach_sync_r;
    logic             tach_seen_r;
    logic             tach_edge_s;
    logic             tach_quiet_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic             stall_r;

    // [0],[1] synchronise; [2] holds the previous synchronised sample.
    assign tach_edge_s  = tach_sync_r[1] & ~tach_sync_r[2];
    // An edge on the boundary clk itself still belongs to the ending period.
    assign tach_quiet_s = ~(tach_seen_r | tach_edge_s);

    // Tach synchroniser and per-period edge latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            tach_sync_r <= 3'b000;
            tach_seen_r <= 1'b0;
        end else begin
            tach_sync_r <= {tach_sync_r[1:0], bus.tach};
            if (boundary_s) begin
                tach_seen_r <= 1'b0;
            end else if (tach_edge_s) begin
                tach_seen_r <= 1'b1;
            end else begin
                tach_seen_r <= tach_seen_r;
            end
        end
    end
`endif

    // Controller FSM: evaluated only on PWM period boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            level_r    <= '0;
            kick_cnt_r <= '0;
            ramp_cnt_r <= '0;
`ifdef FAN_TACH_EN
            stall_cnt_r <= '0;
`endif
        end else if (boundary_s) begin
            case (state_r)
                ST_IDLE: begin
                    level_r    <= '0;
                    kick_cnt_r <= '0;
                    if (bus.fan != 4'd0) begin
                        state_r <= ST_KICK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_KICK: begin
                    if (bus.fan == 4'd0) begin
                        state_r    <= ST_IDLE;
                        kick_cnt_r <= '0;
                    end else if (kick_cnt_r == CNT_W'(KICK_PERIODS - 1)) begin
                        state_r    <= ST_RAMP;
                        level_r    <= 4'd1;
                        kick_cnt_r <= '0;
                        ramp_cnt_r <= '0;
                    end else begin
                        kick_cnt_r <= kick_cnt_r + CNT_W'(1);
                    end
                end
                ST_RAMP: begin
                    if (level_r == bus.fan) begin
                        state_r    <= ST_HOLD;
                        ramp_cnt_r <= '0;
                    end else if (ramp_cnt_r == CNT_W'(RAMP_PERIODS - 1)) begin
                        ramp_cnt_r <= '0;
                        level_r    <= step_s;
                        if (step_s == 4'd0) begin
                            state_r <= ST_IDLE;
                        end else if (step_s == bus.fan) begin
                            state_r <= ST_HOLD;
                        end else begin
                            state_r <= ST_RAMP;
                        end
                    end else begin
                        ramp_cnt_r <= ramp_cnt_r + CNT_W'(1);
                    end
`ifdef FAN_TACH_EN
                    stall_cnt_r <= '0;
`endif
                end
                ST_HOLD: begin
                    if (bus.fan != level_r) begin
                        // A zero request also ramps down rather than cutting.
                        state_r    <= ST_RAMP;
                        ramp_cnt_r <= '0;
`ifdef FAN_TACH_EN
                        stall_cnt_r <= '0;
                    end else if ((level_r != 4'd0) && tach_quiet_s) begin
                        if (stall_cnt_r == CNT_W'(STALL_PERIODS - 1)) begin
                            state_r     <= ST_FAULT;
                            level_r     <= '0;
                            stall_cnt_r <= '0;
                        end else begin
                            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        stall_cnt_r <= '0;
`else
                    end else begin
                        state_r <= ST_HOLD;
`endif
                    end
                end
                ST_FAULT: begin
                    level_r <= '0;
                    if (bus.fan == 4'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_FAULT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    level_r <= '0;
                end
            endcase
        end
    end

    // Output stage. FSM and phase registers only move on tick edges, so the
    // outputs are refreshed on the clk after each tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_d_r    <= 1'b0;
            pwm_out_r   <= 1'b0;
            cur_level_r <= '0;
            busy_r      <= 1'b0;
`ifdef FAN_TACH_EN
            stall_r     <= 1'b0;
`endif
        end else begin
            tick_d_r <= tick_s;
            if (tick_d_r) begin
                cur_level_r <= level_r;
                busy_r      <= (state_r == ST_KICK) || (state_r == ST_RAMP);
`ifdef FAN_TACH_EN
                stall_r     <= (state_r == ST_FAULT);
`endif
                case (state_r)
                    ST_KICK:  pwm_out_r <= 1'b1;
                    ST_FAULT: pwm_out_r <= 1'b0;
                    default:  pwm_out_r <= (phase_s < level_r);
                endcase
            end
        end
    end

    assign bus.pwm_out   = pwm_out_r;
    assign bus.cur_level = cur_level_r;
    assign bus.busy      = busy_r;
`ifdef FAN_TACH_EN
    assign bus.stall     = stall_r;
`else
    assign bus.stall     = 1'b0;
`endif
endmodule
